// File: rtl/matrix_column_scanner.sv
// Purpose : time-multiplexes a latched 5x7 active-low image onto the LED matrix, one column per slot.
// Latency : first column (0) driven CLK_DIV cycles after reset/enable; all outputs registered.
// Backpressure: none; free-running scan, image sampled only at column-0 ticks.
//
// Ports:
//   clock, reset (sync, active-high), enable (0 = dark + scan reinitialised)
//   column_4..column_0 : image columns, bit r = row r, 0 = LED on
//   column_sel : one-hot active-high column drive
//   row_n      : active-low row drive for the selected column
//   frame_start: one-cycle pulse when column 0 is selected and a new image latched
module matrix_column_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] column_4,
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [4:0] column_sel,
    output logic [6:0] row_n,
    output logic       frame_start
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST     = CW'(CLK_DIV - 1);
    // The tick edge itself is the first blanked edge, so the counter
    // only has to cover the remaining BLANK_CYCLES-1 edges.
    localparam logic [BW-1:0] BLANK_RELOAD = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;

    logic [CW-1:0]     cnt;
    logic [2:0]        col_idx;
    logic [4:0][6:0]   shadow;
    logic [BW-1:0]     blank_cnt;

    logic              tick;
    logic [2:0]        next_idx;
    logic [4:0][6:0]   in_image;
    logic [4:0][6:0]   next_image;
    logic [6:0]        next_pattern;

    always_comb begin
        tick     = (cnt == CNT_LAST);
        next_idx = (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
        in_image = {column_4, column_3, column_2, column_1, column_0};
        // At the column-0 tick the shadow is being reloaded on this very edge,
        // so an unblanked pattern must come straight from the inputs.
        next_image   = (next_idx == 3'd0) ? in_image : shadow;
        next_pattern = next_image[next_idx];
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            cnt         <= '0;
            col_idx     <= 3'd4;
            shadow      <= {5{7'h7F}};
            column_sel  <= 5'b00000;
            row_n       <= 7'h7F;
            frame_start <= 1'b0;
            blank_cnt   <= '0;
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                cnt        <= '0;
                col_idx    <= next_idx;
                column_sel <= 5'b00001 << next_idx;
                if (next_idx == 3'd0) begin
                    shadow      <= in_image;
                    frame_start <= 1'b1;
                end
                // Column switch and blanking start together: no edge ever
                // shows the old column's rows on the new column.
                if (BLANK_CYCLES > 0) begin
                    row_n     <= 7'h7F;
                    blank_cnt <= BLANK_RELOAD;
                end else begin
                    row_n <= next_pattern;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (blank_cnt != '0) begin
                    row_n     <= 7'h7F;
                    blank_cnt <= blank_cnt - 1'b1;
                end else begin
                    // Before the first tick col_idx=4 and shadow is all-off,
                    // so this keeps the display dark.
                    row_n <= shadow[col_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_column_scanner.sv
module tb_matrix_column_scanner;

    localparam int CDIV = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] column_4, column_3, column_2, column_1, column_0;

    logic [4:0] sel_b1, sel_b0;
    logic [6:0] row_b1, row_b0;
    logic       fs_b1, fs_b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    matrix_column_scanner #(.CLK_DIV(CDIV), .BLANK_CYCLES(1)) dut_b1 (
        .clock(clock), .reset(reset), .enable(enable),
        .column_4(column_4), .column_3(column_3), .column_2(column_2),
        .column_1(column_1), .column_0(column_0),
        .column_sel(sel_b1), .row_n(row_b1), .frame_start(fs_b1)
    );

    matrix_column_scanner #(.CLK_DIV(CDIV), .BLANK_CYCLES(0)) dut_b0 (
        .clock(clock), .reset(reset), .enable(enable),
        .column_4(column_4), .column_3(column_3), .column_2(column_2),
        .column_1(column_1), .column_0(column_0),
        .column_sel(sel_b0), .row_n(row_b0), .frame_start(fs_b0)
    );

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: t counts enabled edges since the scan was (re)started.
    // Edge CDIV is the first tick; every CDIV edges afterwards is a new slot,
    // slots cycle through columns 0..4, and a frame's image is whatever sat on
    // the inputs at its column-0 tick.
    int         t = 0;
    logic [6:0] img [5];
    logic [4:0] exp_sel = 5'b0;
    logic [6:0] exp_row1 = 7'h7F;
    logic [6:0] exp_row0 = 7'h7F;
    logic       exp_fs = 1'b0;

    always @(posedge clock) begin
        int m, p, col;
        if (reset || !enable) begin
            t = 0;
            for (int i = 0; i < 5; i++) img[i] = 7'h7F;
        end else begin
            t++;
        end
        if (t >= CDIV) begin
            m   = t / CDIV - 1;
            p   = t % CDIV;
            col = m % 5;
            if (p == 0 && col == 0) begin
                img[0] = column_0; img[1] = column_1; img[2] = column_2;
                img[3] = column_3; img[4] = column_4;
            end
            exp_sel  = 5'(1 << col);
            exp_fs   = (p == 0 && col == 0);
            exp_row1 = (p < 1) ? 7'h7F : img[col];
            exp_row0 = img[col];
        end else begin
            exp_sel  = 5'b0;
            exp_fs   = 1'b0;
            exp_row1 = 7'h7F;
            exp_row0 = 7'h7F;
        end
    end

    always @(negedge clock) begin
        check("model_sel_b1", {2'b0, sel_b1}, {2'b0, exp_sel});
        check("model_row_b1", row_b1, exp_row1);
        check("model_fs_b1",  {6'b0, fs_b1}, {6'b0, exp_fs});
        check("model_sel_b0", {2'b0, sel_b0}, {2'b0, exp_sel});
        check("model_row_b0", row_b0, exp_row0);
        check("model_fs_b0",  {6'b0, fs_b0}, {6'b0, exp_fs});
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_img(input logic [34:0] v);
        column_0 = v[6:0];
        column_1 = v[13:7];
        column_2 = v[20:14];
        column_3 = v[27:21];
        column_4 = v[34:28];
    endtask

    // {col4, col3, col2, col1, col0}
    localparam logic [34:0] FILLING = {7'h1C, 7'h22, 7'h41, 7'h3E, 7'h00};
    localparam logic [34:0] ERROR   = {7'h5D, 7'h6B, 7'h77, 7'h6B, 7'h5D};
    localparam logic [34:0] ERR55   = {7'h5D, 7'h6B, 7'h77, 7'h6B, 7'h55};

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        set_img(FILLING);
        adv(2);
        check("reset_sel", {2'b0, sel_b1}, 7'h00);
        check("reset_row", row_b1, 7'h7F);
        check("reset_fs",  {6'b0, fs_b1}, 7'h00);
        reset = 1'b0;

        // Release: dark for three edges, column 0 on the fourth.
        adv(3);
        check("t1_dark_sel", {2'b0, sel_b1}, 7'h00);
        check("t1_dark_row", row_b1, 7'h7F);
        adv(1);
        check("t1_e4_sel", {2'b0, sel_b1}, 7'h01);
        check("t1_e4_fs",  {6'b0, fs_b1}, 7'h01);
        check("t1_e4_row", row_b1, 7'h7F);
        check("t1_e4_row_b0", row_b0, 7'h00);
        adv(1);
        check("t1_e5_row", row_b1, 7'h00);
        check("t1_e5_fs",  {6'b0, fs_b1}, 7'h00);

        // Free run through the columns.
        adv(3);
        check("t2_e8_sel", {2'b0, sel_b1}, 7'h02);
        check("t2_e8_row", row_b1, 7'h7F);
        adv(1);
        check("t2_e9_row", row_b1, 7'h3E);
        adv(4);
        check("t2_e13_sel", {2'b0, sel_b1}, 7'h04);
        check("t2_e13_row", row_b1, 7'h41);

        // Image change while column 2 shown: rest of frame keeps old image.
        set_img(ERROR);
        adv(4);
        check("t3_e17_sel", {2'b0, sel_b1}, 7'h08);
        check("t3_e17_row", row_b1, 7'h22);
        adv(4);
        check("t3_e21_sel", {2'b0, sel_b1}, 7'h10);
        check("t3_e21_row", row_b1, 7'h1C);
        adv(3);
        check("t2_e24_sel", {2'b0, sel_b1}, 7'h01);
        check("t2_e24_fs",  {6'b0, fs_b1}, 7'h01);
        adv(1);
        check("t3_e25_row", row_b1, 7'h5D);

        // Drop enable for three edges while column 3 shown.
        adv(12);
        check("t4_e37_sel", {2'b0, sel_b1}, 7'h08);
        check("t4_e37_row", row_b1, 7'h6B);
        enable = 1'b0;
        adv(1);
        check("t4_off_sel", {2'b0, sel_b1}, 7'h00);
        check("t4_off_row", row_b1, 7'h7F);
        check("t4_off_row_b0", row_b0, 7'h7F);
        adv(2);
        enable = 1'b1;
        adv(3);
        check("t4_re3_sel", {2'b0, sel_b1}, 7'h00);
        adv(1);
        check("t4_re4_sel", {2'b0, sel_b1}, 7'h01);
        check("t4_re4_fs",  {6'b0, fs_b1}, 7'h01);
        adv(1);
        check("t4_re5_row", row_b1, 7'h5D);

        // One-cycle reset mid-slot, then latch bypass with column_0=55.
        adv(1);
        reset = 1'b1;
        set_img(ERR55);
        adv(1);
        check("t5_rst_sel", {2'b0, sel_b1}, 7'h00);
        check("t5_rst_row", row_b1, 7'h7F);
        check("t5_rst_fs",  {6'b0, fs_b1}, 7'h00);
        reset = 1'b0;
        adv(3);
        check("t5_dark_sel", {2'b0, sel_b1}, 7'h00);
        adv(1);
        check("t5_e4_sel", {2'b0, sel_b1}, 7'h01);
        check("t5_e4_fs",  {6'b0, fs_b1}, 7'h01);
        check("t6_sel_b0", {2'b0, sel_b0}, 7'h01);
        check("t6_row_b0", row_b0, 7'h55);
        check("t5_e4_row", row_b1, 7'h7F);
        adv(1);
        check("t5_e5_row", row_b1, 7'h55);

        // Mixed activity, checked by the model every cycle.
        for (int i = 0; i < 150; i++) begin
            adv(1);
            if (i % 9 == 0)
                set_img({7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)});
            if (i == 60) enable = 1'b0;
            if (i == 63) enable = 1'b1;
            if (i == 110) reset = 1'b1;
            if (i == 111) reset = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
